// File: rtl/systolic_result_collector_if.sv
// Column-input / row-output bundle of the systolic result collector.
// slave: collector side; master: array + host readback side.
interface systolic_result_collector_if #(
  parameter int N_COLS = 4
);
  logic [N_COLS*32-1:0] col_data;
  logic [N_COLS-1:0]    col_valid;
  logic [N_COLS*32-1:0] row_data;
  logic                 row_valid;
  logic                 row_ready;
  logic [15:0]          rows_out;
  logic [N_COLS-1:0]    overflow_err;

  modport master (
    output col_data, col_valid, row_ready,
    input  row_data, row_valid, rows_out, overflow_err
  );

  modport slave (
    input  col_data, col_valid, row_ready,
    output row_data, row_valid, rows_out, overflow_err
  );
endinterface

// File: rtl/systolic_result_collector.sv
// De-skews per-column systolic outputs into rows via per-column FIFOs.
// Ports: clk, reset (sync, high), clear (flush), bus (slave modport:
// col_data/col_valid in, row_data/row_valid/row_ready, rows_out, overflow_err).
module systolic_result_collector #(
  parameter int N_COLS = 4,
  parameter int DEPTH  = 4
) (
  input logic clk,
  input logic reset,
  input logic clear,
  systolic_result_collector_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [31:0]   mem_q [N_COLS][DEPTH];
  logic [AW-1:0] wp_q  [N_COLS];
  logic [AW-1:0] rp_q  [N_COLS];
  logic [CW-1:0] cnt_q [N_COLS];
  logic [15:0]   rows_out_q;
  logic [N_COLS-1:0] ovf_q;

  logic [N_COLS-1:0]    ne;
  logic [N_COLS-1:0]    full;
  logic [N_COLS*32-1:0] head;
  logic [N_COLS-1:0]    wr;
  logic [N_COLS-1:0]    ovf;
  logic                 row_valid;
  logic                 pop;

  always_comb begin
    ne   = '0;
    full = '0;
    head = '0;
    for (int c = 0; c < N_COLS; c++) begin
      ne[c]   = cnt_q[c] != '0;
      full[c] = cnt_q[c] == FULL;
      head[c*32 +: 32] = mem_q[c][rp_q[c]];
    end
  end

  assign row_valid = &ne;
  assign pop = row_valid & bus.row_ready & ~clear;
  // A full column may still be written when the same cycle pops.
  assign wr  = bus.col_valid & ~{N_COLS{clear}}
             & (~full | {N_COLS{pop}});
  assign ovf = bus.col_valid & ~{N_COLS{clear}}
             & full & ~{N_COLS{pop}};

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < N_COLS; c++) begin
        wp_q[c]  <= '0;
        rp_q[c]  <= '0;
        cnt_q[c] <= '0;
      end
      rows_out_q <= '0;
      ovf_q      <= '0;
    end else begin
      ovf_q <= ovf_q | ovf;
      if (pop) rows_out_q <= rows_out_q + 16'd1;
      for (int c = 0; c < N_COLS; c++) begin
        if (clear) begin
          wp_q[c]  <= '0;
          rp_q[c]  <= '0;
          cnt_q[c] <= '0;
        end else begin
          if (wr[c]) begin
            mem_q[c][wp_q[c]] <= bus.col_data[c*32 +: 32];
            wp_q[c] <= wp_q[c] + AW'(1);
          end
          if (pop) rp_q[c] <= rp_q[c] + AW'(1);
          cnt_q[c] <= cnt_q[c] + CW'(wr[c]) - CW'(pop);
        end
      end
    end
  end

  assign bus.row_valid    = row_valid;
  assign bus.row_data     = row_valid ? head : '0;
  assign bus.rows_out     = rows_out_q;
  assign bus.overflow_err = ovf_q;
endmodule
